// File: rtl/approx_mac_pkg.sv
// Shared geometry for the approximate Baugh-Wooley MAC: default widths, matrix/stage types
// for the default geometry, and the result-field LSB derivation.
package approx_mac_pkg;

    localparam int IN_WIDTH_DEF   = 9;
    localparam int OUT_WIDTH_DEF  = 2 * IN_WIDTH_DEF;
    localparam int N_BIT_APPR_DEF = 8;
    localparam int N_BIT_RES_DEF  = OUT_WIDTH_DEF - 4;
    localparam int ACC_WIDTH_DEF  = OUT_WIDTH_DEF + 6;

    typedef logic [IN_WIDTH_DEF-1:0][OUT_WIDTH_DEF-1:0] pp_matrix_t;

    typedef struct packed {
        pp_matrix_t               matrix;
        logic [N_BIT_RES_DEF-1:0] rmask;
        logic                     sign;
        logic                     zero;
        logic                     clr;
    } s1_reg_t;

    // First product column covered by the precision mask.
    function automatic int res_lsb(input int out_w, input int n_res);
        return out_w - n_res;
    endfunction

endpackage

// File: rtl/approx_mac_pipe_bw_pp_gen.sv
// Combinational Baugh-Wooley partial-product matrix with approximation and precision gating.
// Row i holds its dots already shifted to their product columns.
module bw_pp_gen
    import approx_mac_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int OUT_WIDTH  = 2 * IN_WIDTH,
    parameter int N_BIT_APPR = N_BIT_APPR_DEF,
    parameter int N_BIT_RES  = OUT_WIDTH - 4
) (
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    input  logic [N_BIT_RES-1:0]        res_mask,
    input  logic [N_BIT_APPR-1:0]       appr_mask,
    output logic [IN_WIDTH-1:0][OUT_WIDTH-1:0] matrix
);

    localparam int RES_LSB = res_lsb(OUT_WIDTH, N_BIT_RES);

    always_comb begin
        matrix = '0;
        // Dots from the sign row (except its MSB) and the MSB of every other row are inverted.
        for (int i = 0; i < IN_WIDTH; i++) begin
            for (int j = 0; j < IN_WIDTH; j++) begin
                matrix[i][i+j] = (a[j] & b[i]) ^ ((i == IN_WIDTH-1) != (j == IN_WIDTH-1));
            end
        end
        matrix[0][IN_WIDTH]    = 1'b1;
        matrix[0][OUT_WIDTH-1] = 1'b1;

        for (int k = 0; k < N_BIT_APPR; k++) begin
            if (!appr_mask[k]) begin
                for (int i = 0; i < IN_WIDTH; i++) begin
                    matrix[i][k] = (i == 0) && (k == 2 || k == 3);
                end
            end
        end

        for (int k = RES_LSB; k < OUT_WIDTH; k++) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                matrix[i][k] = matrix[i][k] & res_mask[k-RES_LSB];
            end
        end
    end

endmodule

// File: rtl/approx_mac_pipe.sv
// Two-stage approximate signed MAC with valid/ready flow control and running accumulator.
// Optional feature: define MAC_SAT_EN for a saturating accumulator with sticky sat_o flag.
module approx_mac_pipe
    import approx_mac_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int OUT_WIDTH  = 2 * IN_WIDTH,
    parameter int N_BIT_APPR = N_BIT_APPR_DEF,
    parameter int N_BIT_RES  = OUT_WIDTH - 4,
    parameter int ACC_WIDTH  = OUT_WIDTH + 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    input  logic [N_BIT_RES-1:0]        res_mask,
    input  logic [N_BIT_APPR-1:0]       appr_mask,
    input  logic                        acc_clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        res,
    output logic [ACC_WIDTH-1:0]        acc
`ifdef MAC_SAT_EN
    ,
    output logic                        sat_o
`endif
);

    localparam int RES_LSB = res_lsb(OUT_WIDTH, N_BIT_RES);

    typedef logic [IN_WIDTH-1:0][OUT_WIDTH-1:0] matrix_t;

    typedef struct packed {
        matrix_t              matrix;
        logic [N_BIT_RES-1:0] rmask;
        logic                 sign;
        logic                 zero;
        logic                 clr;
    } stage1_t;

    matrix_t                     pp_p0;
    stage1_t                     s1_p1;
    logic                        vld_p1;
    logic                        vld_p2;
    logic                        s1_load;
    logic                        s2_adv;
    logic [OUT_WIDTH-1:0]        raw_p1;
    logic [OUT_WIDTH-1:0]        res_next;
    logic signed [ACC_WIDTH-1:0] res_ext;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [OUT_WIDTH-1:0]        res_p2;
    logic signed [ACC_WIDTH-1:0] acc_p2;
`ifdef MAC_SAT_EN
    logic                        ovf;
    logic                        sat_p2;
`endif

    function automatic logic [OUT_WIDTH-1:0] sign_fix(input logic [OUT_WIDTH-1:0] sum,
                                                      input logic [N_BIT_RES-1:0] rmask,
                                                      input logic sign, input logic zero);
        logic [OUT_WIDTH-1:0] r;
        r = sum;
        r[OUT_WIDTH-1:RES_LSB] = sign ? (sum[OUT_WIDTH-1:RES_LSB] | ~rmask)
                                      : (sum[OUT_WIDTH-1:RES_LSB] & rmask);
        return zero ? '0 : r;
    endfunction

`ifdef MAC_SAT_EN
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(input logic signed [ACC_WIDTH-1:0] x,
                                                            input logic signed [ACC_WIDTH-1:0] y,
                                                            output logic of);
        logic signed [ACC_WIDTH:0] s;
        s  = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
        of = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
        if (!of) return s[ACC_WIDTH-1:0];
        return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction
`endif

    assign s2_adv   = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || s2_adv;
    assign s1_load  = in_valid && in_ready;

    bw_pp_gen #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .N_BIT_APPR(N_BIT_APPR),
        .N_BIT_RES (N_BIT_RES)
    ) u_pp (
        .a        (a),
        .b        (b),
        .res_mask (res_mask),
        .appr_mask(appr_mask),
        .matrix   (pp_p0)
    );

    // ---- S1: register gated matrix and per-beat flags ----
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_p1.matrix <= pp_p0;
            s1_p1.rmask  <= res_mask;
            s1_p1.sign   <= a[IN_WIDTH-1] ^ b[IN_WIDTH-1];
            s1_p1.zero   <= (a == '0) || (b == '0);
            s1_p1.clr    <= acc_clear;
        end
    end

    always_comb begin
        raw_p1 = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            raw_p1 = raw_p1 + s1_p1.matrix[i];
        end
        res_next = sign_fix(raw_p1, s1_p1.rmask, s1_p1.sign, s1_p1.zero);
        res_ext  = ACC_WIDTH'(signed'(res_next));
        acc_base = s1_p1.clr ? '0 : acc_p2;
`ifdef MAC_SAT_EN
        ovf      = 1'b0;
        acc_next = sat_add(acc_base, res_ext, ovf);
`else
        acc_next = acc_base + res_ext;
`endif
    end

    // ---- S2: result, accumulator and output valid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            acc_p2 <= '0;
`ifdef MAC_SAT_EN
            sat_p2 <= 1'b0;
`endif
        end else begin
            if (s1_load)     vld_p1 <= 1'b1;
            else if (s2_adv) vld_p1 <= 1'b0;

            if (s2_adv)         vld_p2 <= 1'b1;
            else if (out_ready) vld_p2 <= 1'b0;

            if (s2_adv) begin
                res_p2 <= res_next;
                acc_p2 <= acc_next;
`ifdef MAC_SAT_EN
                sat_p2 <= (s1_p1.clr ? 1'b0 : sat_p2) | ovf;
`endif
            end
        end
    end

    assign out_valid = vld_p2;
    assign res       = res_p2;
    assign acc       = acc_p2;
`ifdef MAC_SAT_EN
    assign sat_o     = sat_p2;
`endif

endmodule

// File: tb/tb_approx_mac_pipe.sv
// Scoreboard bench for approx_mac_pipe (ACC_WIDTH=20); honours MAC_SAT_EN when defined.
module tb_approx_mac_pipe;

    localparam int IW = 9;
    localparam int OW = 18;
    localparam int NA = 8;
    localparam int NR = 14;
    localparam int AW = 20;
    localparam int RL = OW - NR;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] a;
    logic signed [IW-1:0] b;
    logic [NR-1:0]        res_mask;
    logic [NA-1:0]        appr_mask;
    logic                 acc_clear;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW-1:0]        res;
    logic [AW-1:0]        acc;
`ifdef MAC_SAT_EN
    logic                 sat_o;
`endif

    approx_mac_pipe #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .N_BIT_APPR(NA), .N_BIT_RES(NR), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .res_mask(res_mask), .appr_mask(appr_mask), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .acc(acc)
`ifdef MAC_SAT_EN
        , .sat_o(sat_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] res;
        logic [AW-1:0] acc;
        bit            sat;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    longint acc_m  = 0;
    bit     sat_m  = 0;
    int     rdy_mode = 0;
    int     rdy_ph   = 0;

    // Approximate product from the arithmetic definition: weighted sum of individual dots.
    function automatic bit gate_dot(input bit d, input int c, input bit row0,
                                    input logic [NR-1:0] rm, input logic [NA-1:0] am);
        bit g;
        g = d;
        if (c < NA && !am[c]) g = row0 && (c == 2 || c == 3);
        if (c >= RL) g = g & rm[c-RL];
        return g;
    endfunction

    function automatic logic [OW-1:0] model_prod(input logic signed [IW-1:0] x,
                                                 input logic signed [IW-1:0] y,
                                                 input logic [NR-1:0] rm, input logic [NA-1:0] am);
        longint        sum;
        logic [OW-1:0] raw;
        logic [NR-1:0] f;
        bit            d;
        if (x == 0 || y == 0) return '0;
        if ((&rm) && (&am)) return OW'(longint'(x) * longint'(y));
        sum = 0;
        for (int i = 0; i < IW; i++) begin
            for (int j = 0; j < IW; j++) begin
                d = x[j] & y[i];
                if ((i == IW-1) != (j == IW-1)) d = ~d;
                sum += longint'(gate_dot(d, i + j, i == 0, rm, am)) << (i + j);
            end
        end
        sum += longint'(gate_dot(1'b1, IW, 1'b0, rm, am)) << IW;
        sum += longint'(gate_dot(1'b1, OW - 1, 1'b0, rm, am)) << (OW - 1);
        raw = OW'(sum);
        f   = raw[OW-1:RL];
        raw[OW-1:RL] = (x[IW-1] ^ y[IW-1]) ? (f | ~rm) : (f & rm);
        return raw;
    endfunction

    function automatic void model_acc(input logic [OW-1:0] r, input bit clr);
        longint s;
        longint mx;
        longint mn;
        mx = (longint'(1) << (AW-1)) - 1;
        mn = -(longint'(1) << (AW-1));
        s  = (clr ? 0 : acc_m) + longint'($signed(r));
`ifdef MAC_SAT_EN
        if (clr) sat_m = 0;
        if (s > mx) begin s = mx; sat_m = 1; end
        else if (s < mn) begin s = mn; sat_m = 1; end
`else
        s = s & ((longint'(1) << AW) - 1);
        if (s > mx) s -= (longint'(1) << AW);
`endif
        acc_m = s;
    endfunction

    task automatic send(input logic signed [IW-1:0] x, input logic signed [IW-1:0] y,
                        input logic [NR-1:0] rm, input logic [NA-1:0] am, input bit clr,
                        input bit chk_res, input logic [OW-1:0] want_res,
                        input bit chk_acc, input logic [AW-1:0] want_acc);
        exp_t e;
        int   waitc;
        bit   ok;
        waitc = 0;
        ok    = 0;
        a = x; b = y; res_mask = rm; appr_mask = am; acc_clear = clr; in_valid = 1'b1;
        while (!ok && waitc < 500) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else waitc++;
        end
        if (ok) begin
            e.res = chk_res ? want_res : model_prod(x, y, rm, am);
            model_acc(e.res, clr);
            e.acc = chk_acc ? want_acc : AW'(acc_m);
            e.sat = sat_m;
            q.push_back(e);
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic exact(input int x, input int y, input bit clr, input logic [OW-1:0] want);
        send(IW'(x), IW'(y), '1, '1, clr, 1'b1, want, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    // Consumer readiness pattern, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
            2: out_ready = 1'(($urandom_range(0, 1)));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every presented result must match the head of the queue, also while stalled.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out res=%0h acc=%0h required=none", res, acc);
            end else begin
                checks++;
                if (res !== q[0].res) begin
                    errors++;
                    $display("FAIL res got=%0h required=%0h", res, q[0].res);
                end
                checks++;
                if (acc !== q[0].acc) begin
                    errors++;
                    $display("FAIL acc got=%0h required=%0h", acc, q[0].acc);
                end
`ifdef MAC_SAT_EN
                checks++;
                if (sat_o !== q[0].sat) begin
                    errors++;
                    $display("FAIL sat_o got=%0b required=%0b", sat_o, q[0].sat);
                end
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ovf_acc;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; res_mask = '1; appr_mask = '1;
        acc_clear = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_res", longint'(res), 0);
        chk("rst_acc", longint'(acc), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
`ifdef MAC_SAT_EN
        chk("rst_sat", longint'(sat_o), 0);
`endif
        rst = 1'b0;

        exact(-256, -256, 1'b1, 18'h10000);
        exact(127, -3, 1'b0, 18'h3FE83);
        send(IW'(0), IW'(-5), NR'($urandom), NA'($urandom), 1'b0, 1'b1, '0, 1'b0, '0);
        send(IW'(-100), IW'(50), 14'h0FFF, '1, 1'b0, 1'b1, 18'h3EC78, 1'b0, '0);
        send(IW'(100), IW'(50), 14'h0FFF, '1, 1'b0, 1'b1, 18'h01388, 1'b0, '0);
        send(IW'(-100), IW'(50), NR'($urandom), 8'h00, 1'b0, 1'b0, '0, 1'b0, '0);
        send(IW'(3), IW'(4), '1, '1, 1'b1, 1'b1, 18'd12, 1'b1, 20'd12);
        send(IW'(5), IW'(6), '1, '1, 1'b0, 1'b1, 18'd30, 1'b1, 20'd42);
        send(IW'(2), IW'(2), '1, '1, 1'b1, 1'b1, 18'd4, 1'b1, 20'd4);
        drain();

        // Backpressure: ready toggles 1,0,0,1 while streaming.
        rdy_mode = 1; rdy_ph = 0;
        for (int i = 0; i < 6; i++)
            send(IW'($urandom), IW'($urandom), '1, '1, 1'b0, 1'b0, '0, 1'b0, '0);
        drain();
        rdy_mode = 0;

        // Overflow: 255*255 repeated; ninth beat crosses the 20-bit signed range.
`ifdef MAC_SAT_EN
        ovf_acc = 20'h7FFFF;
`else
        ovf_acc = 20'h8EE09;
`endif
        for (int i = 0; i < 11; i++)
            send(IW'(255), IW'(255), '1, '1, i == 0, 1'b1, 18'd65025, i == 8, ovf_acc);
        send(IW'(1), IW'(1), '1, '1, 1'b1, 1'b1, 18'd1, 1'b1, 20'd1);
        drain();

        // Randomised traffic with random consumer readiness.
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            logic [NR-1:0] rm;
            logic [NA-1:0] am;
            rm = ($urandom_range(0, 1) == 0) ? '1 : NR'($urandom);
            am = ($urandom_range(0, 1) == 0) ? '1 : NA'($urandom);
            send(IW'($urandom), IW'($urandom), rm, am, $urandom_range(0, 7) == 0,
                 1'b0, '0, 1'b0, '0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Reset with beats in flight: nothing emitted afterwards, accumulator zeroed.
        rdy_mode = 3;
        idle(1);
        send(IW'(7), IW'(9), '1, '1, 1'b0, 1'b0, '0, 1'b0, '0);
        send(IW'(-8), IW'(11), '1, '1, 1'b0, 1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        acc_m = 0;
        sat_m = 0;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_acc", longint'(acc), 0);
        chk("midrst_res", longint'(res), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        rdy_mode = 0;
        idle(3);
        chk("post_rst_quiet", longint'(out_valid), 0);
        send(IW'(-7), IW'(6), '1, '1, 1'b0, 1'b1, 18'h3FFD6, 1'b1, 20'hFFFD6);
        send(IW'(10), IW'(10), '1, '1, 1'b0, 1'b1, 18'd100, 1'b1, 20'd58);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
